// File: rtl/l2_miss_queue_if.sv
// Request, response and L2-side signal bundle for l2_miss_queue.
// The slave modport is the queue itself; the master modport is the requester/L2 side.
interface l2_miss_queue_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic                  resp_hit;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  l2_read;
    logic [ADDR_WIDTH-1:0] l2_addr;
    logic                  l2_hit;
    logic [DATA_WIDTH-1:0] l2_read_data;

    modport master (
        output req_valid, req_addr, resp_ready, l2_hit, l2_read_data,
        input  req_ready, resp_valid, resp_addr, resp_hit, resp_data, l2_read, l2_addr
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, l2_hit, l2_read_data,
        output req_ready, resp_valid, resp_addr, resp_hit, resp_data, l2_read, l2_addr
    );
endinterface

// File: rtl/l2_miss_queue.sv
// L1-miss FIFO feeding a single-outstanding L2 lookup with a valid/ready response channel.
// Optional hit/miss counters are enabled with `define L2Q_STATS_EN.
module l2_miss_queue #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int L2_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    l2_miss_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef L2Q_STATS_EN
    ,
    output logic [15:0]                  stat_hits,
    output logic [15:0]                  stat_misses
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(L2_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic [LAT_W-1:0]      wait_cnt;
    logic                  l2_read_q;
    logic                  resp_valid_q;
    logic                  resp_hit_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  push;
    logic                  pop;
    logic                  sample;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ready comes from the registered count, so a full FIFO rejects a push even while popping.
    assign bus.req_ready  = (count != CNT_W'(DEPTH));
    assign push           = bus.req_valid && bus.req_ready;
    assign pop            = (state == IDLE) && (count != '0);
    assign sample         = (state == WAIT) && (wait_cnt == LAT_W'(1));

    assign bus.l2_read    = l2_read_q;
    assign bus.l2_addr    = inflight_addr;
    assign bus.resp_addr  = inflight_addr;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_data  = resp_data_q;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.req_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            inflight_addr <= '0;
            wait_cnt      <= '0;
            l2_read_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        inflight_addr <= fifo_mem[rd_ptr];
                        l2_read_q     <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    l2_read_q <= 1'b0;
                    wait_cnt  <= LAT_W'(L2_LAT);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (sample) begin
                        resp_hit_q   <= bus.l2_hit;
                        resp_data_q  <= bus.l2_read_data;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L2Q_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (sample) begin
            if (bus.l2_hit) stat_hits   <= sat_inc(stat_hits);
            else            stat_misses <= sat_inc(stat_misses);
        end
    end
`endif
endmodule

// File: tb/tb_l2_miss_queue.sv
// Directed bench for l2_miss_queue: latency, fill/ordering, backpressure, miss, async reset, stats.
module tb_l2_miss_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  count;
    logic        stub_hit  = 1'b0;
    logic        stub_mode = 1'b0;
    logic [31:0] stub_data = 32'h0;
    int          tests = 0;
    int          fails = 0;
`ifdef L2Q_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
`endif

    l2_miss_queue_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

    l2_miss_queue #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .DEPTH(4), .L2_LAT(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .count (count)
`ifdef L2Q_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // L2 stub: fixed data, or an address-tagged word so ordering is visible in the data too.
    assign bus.l2_hit       = stub_hit;
    assign bus.l2_read_data = stub_mode ? (32'hCAFE0000 | {21'b0, bus.l2_addr}) : stub_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [10:0] a, input logic h, input logic [31:0] d);
        int n;
        stub_mode = 1'b0;
        stub_hit  = h;
        stub_data = d;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        n = 0;
        while (!bus.req_ready && n < 50) begin step(); n++; end
        step();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 50) begin step(); n++; end
        check("req_resp_valid", bus.resp_valid, 1);
        check("req_resp_addr", bus.resp_addr, a);
        check("req_resp_hit", bus.resp_hit, h);
        check("req_resp_data", bus.resp_data, d);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] addrs [6];
        logic [10:0] snap_addr;
        logic [31:0] snap_data;
        logic        stable;
        logic        saw_read;
        int          got;
        int          nl;
        int          nr;
        logic [10:0] ra;
        logic        acc;

        addrs = '{11'h000, 11'h020, 11'h040, 11'h060, 11'h080, 11'h0A0};
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;

        // reset state
        #2 rst = 1'b0;
        step();
        step();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_count", count, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_l2_read", bus.l2_read, 0);
        check("rst_l2_addr", bus.l2_addr, 0);
        check("rst_resp_data", bus.resp_data, 0);
        rst = 1'b1;
        step();

        // single hit request, latency and one-cycle strobe
        stub_hit = 1'b1;
        stub_data = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        bus.req_addr  = 11'h020;
        step();
        bus.req_valid = 1'b0;
        check("t1_count_e0", count, 1);
        check("t1_l2_read_e0", bus.l2_read, 0);
        step();
        check("t1_l2_read_e1", bus.l2_read, 1);
        check("t1_l2_addr_e1", bus.l2_addr, 11'h020);
        check("t1_count_e1", count, 0);
        check("t1_resp_valid_e1", bus.resp_valid, 0);
        step();
        check("t1_l2_read_e2", bus.l2_read, 0);
        check("t1_resp_valid_e2", bus.resp_valid, 0);
        step();
        check("t1_resp_valid_e3", bus.resp_valid, 1);
        check("t1_resp_addr", bus.resp_addr, 11'h020);
        check("t1_resp_hit", bus.resp_hit, 1);
        check("t1_resp_data", bus.resp_data, 32'hDEADBEEF);

        // backpressure for 10 cycles while the L2 stub changes underneath
        snap_addr = bus.resp_addr;
        snap_data = bus.resp_data;
        stub_hit  = 1'b0;
        stub_data = 32'h12345678;
        stable    = 1'b1;
        saw_read  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!(bus.resp_valid === 1'b1 && bus.resp_addr === snap_addr &&
                  bus.resp_data === snap_data && bus.resp_hit === 1'b1 && count === 3'd0))
                stable = 1'b0;
            if (bus.l2_read !== 1'b0) saw_read = 1'b1;
        end
        check("bp_stable", stable, 1);
        check("bp_no_read", saw_read, 0);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check("bp_resp_dropped", bus.resp_valid, 0);

        // miss passes through
        do_req(11'h100, 1'b0, 32'h0);

        // fill: one in flight, four queued, sixth stalls
        stub_mode = 1'b1;
        stub_hit  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = addrs[i];
            check("fill_ready", bus.req_ready, 1);
            step();
        end
        check("fill_count", count, 4);
        check("fill_req_ready", bus.req_ready, 0);
        check("fill_resp_valid", bus.resp_valid, 1);
        check("fill_resp_addr0", bus.resp_addr, 11'h000);
        bus.req_addr = addrs[5];
        for (int i = 0; i < 3; i++) begin
            step();
            check("fill_stall_count", count, 4);
        end
        bus.resp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            if (bus.resp_valid) begin
                check("fill_order_addr", bus.resp_addr, addrs[got]);
                check("fill_order_data", bus.resp_data, 32'hCAFE0000 | {21'b0, addrs[got]});
                got++;
            end
            acc = bus.req_valid && bus.req_ready;
            step();
            if (acc) bus.req_valid = 1'b0;
        end
        check("fill_resp_total", got, 6);
        check("fill_drained_count", count, 0);
        bus.resp_ready = 1'b0;
        step();

        // asynchronous reset during WAIT with two entries queued
        stub_mode = 1'b0;
        stub_hit  = 1'b1;
        stub_data = 32'h55AA55AA;
        bus.req_valid = 1'b1;
        bus.req_addr = 11'h200; step();
        bus.req_addr = 11'h220; step();
        bus.req_addr = 11'h240; step();
        bus.req_valid = 1'b0;
        check("rr_count_before", count, 2);
        check("rr_l2_addr_before", bus.l2_addr, 11'h200);
        #2 rst = 1'b0;
        #1;
        check("rr_count", count, 0);
        check("rr_req_ready", bus.req_ready, 1);
        check("rr_l2_read", bus.l2_read, 0);
        check("rr_l2_addr", bus.l2_addr, 0);
        check("rr_resp_valid", bus.resp_valid, 0);
        check("rr_resp_addr", bus.resp_addr, 0);
        check("rr_resp_hit", bus.resp_hit, 0);
        check("rr_resp_data", bus.resp_data, 0);
        step();
        rst = 1'b1;
        step();
        stub_data = 32'h0BADF00D;
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 11'h040;
        step();
        bus.req_valid = 1'b0;
        nl = 0;
        nr = 0;
        ra = '0;
        for (int i = 0; i < 20; i++) begin
            if (bus.l2_read) nl++;
            if (bus.resp_valid) begin nr++; ra = bus.resp_addr; end
            step();
        end
        check("rr_post_reads", nl, 1);
        check("rr_post_resps", nr, 1);
        check("rr_post_addr", ra, 11'h040);
        bus.resp_ready = 1'b0;

        // statistics: three hits then two misses from a clean reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        do_req(11'h010, 1'b1, 32'h00000011);
        do_req(11'h030, 1'b1, 32'h00000033);
        do_req(11'h050, 1'b1, 32'h00000055);
        do_req(11'h070, 1'b0, 32'h00000077);
        do_req(11'h090, 1'b0, 32'h00000099);
`ifdef L2Q_STATS_EN
        check("stat_hits", stat_hits, 3);
        check("stat_misses", stat_misses, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/l2_miss_queue.md
# l2_miss_queue

Miss-request queue sitting directly upstream of the 4-way set-associative L2 (`cache_4wayl2`). It buffers L1 miss addresses in a small FIFO, issues them to the L2 one at a time as a single-cycle `read` pulse, waits a fixed lookup latency, captures `hit`/`read_data`, and returns the result to the requester over a valid/ready response channel. Only one L2 access is ever in flight.

## Interface
- `ADDR_WIDTH`, 11: byte address width, matches L2 `addr`.
- `DATA_WIDTH`, 32: data width, matches L2 `read_data`.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `L2_LAT`, 1: cycles after the `l2_read` cycle before `l2_hit`/`l2_read_data` are sampled, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: miss request present.
- `req_ready` out 1: FIFO can accept, equal to `count != DEPTH`.
- `req_addr` in ADDR_WIDTH: miss address.
- `resp_valid` out 1: response held.
- `resp_ready` in 1: consumer accepts response.
- `resp_addr` out ADDR_WIDTH: address of the returned access.
- `resp_hit` out 1: captured L2 hit.
- `resp_data` out DATA_WIDTH: captured L2 data.
- `l2_read` out 1: one-cycle read strobe to L2.
- `l2_addr` out ADDR_WIDTH: L2 address.
- `l2_hit` in 1: L2 hit.
- `l2_read_data` in DATA_WIDTH: L2 data.
- `count` out $clog2(DEPTH+1): FIFO occupancy, excluding the in-flight entry.

## Operation
- FIFO push on `req_valid && req_ready`. Pop only on the IDLE→ISSUE transition.
- FSM states and transitions:
  - IDLE: if `count != 0` → ISSUE; load the head address into the in-flight register and pop.
  - ISSUE: `l2_read = 1` for exactly this cycle → WAIT; load the wait counter with `L2_LAT`.
  - WAIT: decrement each cycle. On the edge ending the last WAIT cycle, capture `l2_hit`/`l2_read_data` into the `resp_*` registers → RESP.
  - RESP: `resp_valid = 1`. On `resp_ready` → IDLE.
- `l2_addr` and `resp_addr` are driven from the in-flight register. They are stable from ISSUE until the next pop.
- Misses are passed through unchanged: `resp_hit = 0`, `resp_data` = whatever the L2 drove at the sample edge.
- Push and pop in the same cycle while full: push is rejected, because `req_ready` derives from the registered `count`.
- Push into an empty FIFO gives no bypass; the entry is popped at the earliest on the next edge.
- FIFO pointers wrap modulo DEPTH.
- `rst` low forces the following immediately, regardless of clock:
  - state IDLE
  - FIFO emptied (`count` 0)
  - in-flight entry dropped
  - `l2_read`, `l2_addr`, `resp_valid`, `resp_hit`, `resp_addr`, `resp_data` all 0
  - `req_ready` 1

## Timing
- Request accepted at edge E0. ISSUE entered at E1, so `l2_read` is high from E1 to E2. WAIT runs for `L2_LAT` cycles. `resp_valid` rises after edge E(2+L2_LAT); with defaults, after E3.
- Minimum request-to-request issue spacing: `L2_LAT + 3` cycles. That is ISSUE + `L2_LAT` × WAIT + RESP (response accepted in its first cycle) + IDLE.
- `resp_*` outputs hold while `resp_valid && !resp_ready`. No new `l2_read` is issued during RESP.

## Configuration
- `L2Q_STATS_EN` defined:
  - Adds outputs `stat_hits` and `stat_misses`, each 16 bits.
  - Exactly one of them increments on each sample edge, according to `l2_hit`.
  - Both saturate at 0xFFFF and are cleared by `rst`.
- `L2Q_STATS_EN` undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Single request (`L2_LAT` = 1), `req_addr` = 0x020, L2 stub drives hit = 1, data = 0xDEADBEEF:
  - `l2_read` is high for exactly one cycle with `l2_addr` = 0x020.
  - `resp_valid` rises 3 edges after acceptance with `resp_addr` = 0x020, `resp_hit` = 1, `resp_data` = 0xDEADBEEF.
- Fill (`DEPTH` = 4, `resp_ready` = 0), offer 0x000, 0x020, 0x040, 0x060, 0x080, 0x0A0 back to back:
  - 0x000 goes in flight and the next four are queued, so `count` = 4 and `req_ready` = 0.
  - 0x0A0 stalls until `resp_ready` rises.
  - Responses then return in order 0x000…0x0A0.
- Backpressure, `resp_ready` = 0 for 10 cycles during RESP:
  - `resp_*` outputs stay constant.
  - No `l2_read` is issued.
  - `count` stays unchanged when no pushes are offered.
- Miss, `req_addr` = 0x100 with stub hit = 0, data = 0x0 → `resp_hit` = 0, `resp_data` = 0x0.
- Reset mid-operation, `rst` low during WAIT with 2 entries queued:
  - Outputs go to their reset values immediately and `count` = 0.
  - After release, request 0x040 completes normally and no stale response appears.
- With `L2Q_STATS_EN` defined, 3 hits then 2 misses → `stat_hits` = 3, `stat_misses` = 2.
